decoder_arbiter: RTL and testbench
==================================

DECODER_ARBITER -- requirements
Module: decoder_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 1, idle cycles with sel=0 between consecutive grants; legal range 1..15.
REQ-002 Parameter MAX_HOLD, default 16, grant cycle limit when timeout is compiled in; legal range 2..255.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req  input  3  level request per requester 0..2; held high for the whole use of the decoder.
REQ-006 Port gnt  output  3  one-hot grant; at most one bit set.
REQ-007 Port sel  output  2  decoder select code: owner index+1 while granted, 0 otherwise; drives decoder in1:in0 (sel[1]=in1, sel[0]=in0).
REQ-008 Port busy  output  1  high in GRANT and GAP states.
REQ-009 Port timeout  output  1  one-cycle pulse on forced revoke; constant 0 when timeout is compiled out.

Function
REQ-010 States: IDLE, GRANT, GAP; encoding is internal, one state register.
REQ-011 IDLE: no effective request -> stay; any effective request -> GRANT with owner chosen round-robin, starting at index (last+1) mod 3.
REQ-012 Effective request = req[i] AND NOT lock[i]; lock is used only by timeout.
REQ-013 Latency: req sampled high in IDLE -> gnt/sel valid on the next rising edge (1 cycle); all outputs registered.
REQ-014 GRANT: gnt/sel stay stable while req[owner]=1; req[owner]=0 sampled -> GAP, with gnt=0 and sel=0 from that edge.
REQ-015 Requests from non-owners during GRANT or GAP are ignored, neither queued nor lost; they are re-evaluated in IDLE.
REQ-016 GAP: count GAP_CYCLES cycles with gnt=0 and sel=0, then IDLE; GAP_CYCLES=1 gives exactly one dead cycle.
REQ-017 On every entry into GRANT, last := owner; after reset last=2, so requester 0 has first priority.
REQ-018 Simultaneous requests: the winner is the first set effective bit scanning last+1, last+2, last+3 (mod 3).
REQ-019 A requester that re-raises req in the cycle directly after its own GAP ends competes normally and has lowest priority.
REQ-020 Never two grants in one cycle; sel is never nonzero while gnt=0.
REQ-021 A req pulse shorter than one clock period is not guaranteed to be seen; no internal input synchronisation.

Reset
REQ-022 rst high: asynchronously state=IDLE, gnt=0, sel=0, busy=0, timeout=0, last=2, gap and hold counters=0, lock=0.
REQ-023 rst asserted mid-GRANT drops the grant immediately, without waiting for a clock edge; after release, arbitration restarts from requester 0 priority.
REQ-024 First grant possible on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro DECODER_ARBITER_TIMEOUT_EN defined: a hold counter counts GRANT cycles.
- When the counter reaches MAX_HOLD: GRANT -> GAP, timeout pulses one cycle, lock[owner]:=1.
- lock[i] clears when req[i] is sampled 0.
REQ-026 Macro undefined: no hold counter or lock logic; a grant lasts until release; timeout tied 0.

Structure
REQ-027 Shared package decoder_pkg holds:
- state typedef (IDLE/GRANT/GAP);
- constants NUM_REQ=3 and SEL_W=2;
- SEL_NONE=2'd0.
REQ-028 One sub-module rr_pick: combinational 3-way round-robin picker (inputs: effective req, last; outputs: found, index).
REQ-029 Top-level RTL target 120-250 lines, excluding package.

Verification
REQ-030 Single request: reset, req=001 at cycle 0 -> gnt=001, sel=01 at cycle 1; req=000 at cycle 5 -> gnt=000, sel=00 at cycle 6; busy low at cycle 7 with GAP_CYCLES=1.
REQ-031 All request: req=111 held, each owner releases after 3 cycles then re-raises -> grant order 0,1,2,0, sel 01,10,11,01, one zero cycle between grants.
REQ-032 Contention during grant: owner 1 granted; req[2] rises mid-grant -> no change to gnt; after release and GAP -> gnt=100, sel=11.
REQ-033 Reset mid-operation: rst pulsed high mid-GRANT between clock edges -> gnt=000, sel=00 immediately; post-reset req=110 -> gnt=010 first.
REQ-034 Timeout, with DECODER_ARBITER_TIMEOUT_EN and MAX_HOLD=4: req=001 held -> gnt=001 for 4 cycles, timeout pulses once, then gnt=000; req[0] held -> no regrant; drop req[0] 1 cycle and re-raise -> regrant.
REQ-035 Timeout compiled out: same stimulus as REQ-034 -> gnt=001 held for 100 cycles, timeout stays 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared states, widths and round-robin index helper for decoder_arbiter
package decoder_pkg;
  localparam int NUM_REQ = 3;
  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_NONE = 2'd0;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/decoder_arbiter_rr_pick.sv
// rr_pick: combinational 3-way round-robin picker scanning last+1, last+2, last+3 (mod 3)
module rr_pick
  import decoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               found,
  output logic [SEL_W-1:0]   index
);
  logic [SEL_W-1:0] c0, c1;
  assign c0 = next_idx(last);
  assign c1 = next_idx(c0);
  assign found = |req;
  assign index = req[c0] ? c0 : req[c1] ? c1 : last;
endmodule

// File: rtl/decoder_arbiter.sv
// decoder_arbiter: round-robin arbiter driving a 2-bit decoder select with a dead gap between grants.
// Define DECODER_ARBITER_TIMEOUT_EN to add a MAX_HOLD grant limit with per-requester lockout.
module decoder_arbiter
  import decoder_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);
  state_t state, state_n;
  logic [SEL_W-1:0] owner, owner_n, last, last_n, index;
  logic [3:0] gap_cnt, gap_n;
  logic [NUM_REQ-1:0] eff;
  logic found, expire, timeout_q, timeout_n;
`ifdef DECODER_ARBITER_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_n;
  logic [NUM_REQ-1:0] lock, lock_n;
  assign eff = req & ~lock;
  assign expire = hold_cnt == 8'(MAX_HOLD);
  always_comb begin
    hold_n = (state_n == GRANT) ? ((state == GRANT) ? hold_cnt + 8'd1 : 8'd1) : 8'd0;
    lock_n = (lock | (timeout_n ? 3'(1) << owner : 3'd0)) & req;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_cnt <= '0;
      lock <= '0;
    end else begin
      hold_cnt <= hold_n;
      lock <= lock_n;
    end
`else
  assign eff = req;
  assign expire = 1'b0;
`endif
  rr_pick u_pick (.req(eff), .last(last), .found(found), .index(index));
  // The final gap cycle arbitrates directly so GAP_CYCLES=1 leaves exactly one dead cycle.
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n = last;
    gap_n = gap_cnt;
    timeout_n = 1'b0;
    if (state == GRANT && (!req[owner] || expire)) begin
      state_n = GAP;
      gap_n = 4'd1;
      timeout_n = expire & req[owner];
    end else if (state == IDLE || (state == GAP && gap_cnt == 4'(GAP_CYCLES))) begin
      state_n = found ? GRANT : IDLE;
      owner_n = found ? index : owner;
      last_n = found ? index : last;
      gap_n = 4'd0;
    end else if (state == GAP) begin
      gap_n = gap_cnt + 4'd1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last <= 2'd2;
      gap_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last <= last_n;
      gap_cnt <= gap_n;
      timeout_q <= timeout_n;
    end
  assign gnt = (state == GRANT) ? 3'(1) << owner : '0;
  assign sel = (state == GRANT) ? owner + 2'd1 : SEL_NONE;
  assign busy = state != IDLE;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_decoder_arbiter.sv
// tb_decoder_arbiter: directed self-checking bench for decoder_arbiter
module tb_decoder_arbiter;
  logic clk = 0, rst = 1;
  logic [2:0] req = 0;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic busy, timeout;
  int tests = 0, fails = 0;

  decoder_arbiter #(.GAP_CYCLES(1), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    req = 0;
    #3;
    tests++;
    if ({gnt, sel, busy, timeout} !== 7'd0) begin
      fails++;
      $display("FAIL reset_outputs got gnt=%b sel=%b busy=%b timeout=%b want all 0", gnt, sel, busy, timeout);
    end
    tick(2);
    rst = 0;
  endtask

  task automatic test_single;
    req = 3'b001;
    tick();
    tests++;
    if (gnt !== 3'b001 || sel !== 2'b01 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant got gnt=%b sel=%b busy=%b want 001 01 1", gnt, sel, busy);
    end
    tick(4);
    tests++;
    if (gnt !== 3'b001 || sel !== 2'b01) begin
      fails++;
      $display("FAIL single_hold got gnt=%b sel=%b want 001 01", gnt, sel);
    end
    req = 0;
    tick();
    tests++;
    if (gnt !== 3'b000 || sel !== 2'b00 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_gap got gnt=%b sel=%b busy=%b want 000 00 1", gnt, sel, busy);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || gnt !== 3'b000) begin
      fails++;
      $display("FAIL single_idle got busy=%b gnt=%b want 0 000", busy, gnt);
    end
  endtask

  task automatic test_all_req;
    int order [4] = '{0, 1, 2, 0};
    rst = 1;
    tick();
    rst = 0;
    req = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [2:0] eg;
      logic [1:0] es;
      eg = 3'(1) << order[k];
      es = 2'(order[k] + 1);
      tests++;
      if (gnt !== eg || sel !== es) begin
        fails++;
        $display("FAIL all_grant%0d got gnt=%b sel=%b want %b %b", k, gnt, sel, eg, es);
      end
      tick(2);
      tests++;
      if (gnt !== eg) begin
        fails++;
        $display("FAIL all_hold%0d got gnt=%b want %b", k, gnt, eg);
      end
      req = 3'b111 & ~eg;
      tick();
      tests++;
      if (gnt !== 3'b000 || sel !== 2'b00) begin
        fails++;
        $display("FAIL all_gap%0d got gnt=%b sel=%b want 000 00", k, gnt, sel);
      end
      req = 3'b111;
      if (k < 3) tick();
    end
    req = 0;
    tick(2);
  endtask

  task automatic test_contention;
    req = 3'b010;
    tick();
    tests++;
    if (gnt !== 3'b010 || sel !== 2'b10) begin
      fails++;
      $display("FAIL cont_owner1 got gnt=%b sel=%b want 010 10", gnt, sel);
    end
    tick();
    req = 3'b110;
    tick(2);
    tests++;
    if (gnt !== 3'b010 || sel !== 2'b10) begin
      fails++;
      $display("FAIL cont_ignored got gnt=%b sel=%b want 010 10", gnt, sel);
    end
    req = 3'b100;
    tick();
    tests++;
    if (gnt !== 3'b000 || sel !== 2'b00) begin
      fails++;
      $display("FAIL cont_gap got gnt=%b sel=%b want 000 00", gnt, sel);
    end
    tick();
    tests++;
    if (gnt !== 3'b100 || sel !== 2'b11) begin
      fails++;
      $display("FAIL cont_next got gnt=%b sel=%b want 100 11", gnt, sel);
    end
    req = 0;
    tick(2);
  endtask

  task automatic test_reset_mid;
    req = 3'b001;
    tick();
    tests++;
    if (gnt !== 3'b001) begin
      fails++;
      $display("FAIL rstmid_pre got gnt=%b want 001", gnt);
    end
    #2 rst = 1;
    #1;
    tests++;
    if (gnt !== 3'b000 || sel !== 2'b00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async got gnt=%b sel=%b busy=%b want 000 00 0", gnt, sel, busy);
    end
    #1 rst = 0;
    req = 3'b110;
    tick();
    tests++;
    if (gnt !== 3'b010 || sel !== 2'b10) begin
      fails++;
      $display("FAIL rstmid_first got gnt=%b sel=%b want 010 10", gnt, sel);
    end
    req = 0;
    tick(2);
  endtask

  task automatic test_timeout;
    int pulses = 0;
    req = 3'b001;
    tick();
`ifdef DECODER_ARBITER_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (gnt !== 3'b001 || timeout !== 1'b0) begin
        fails++;
        $display("FAIL to_hold%0d got gnt=%b timeout=%b want 001 0", c, gnt, timeout);
      end
      tick();
    end
    tests++;
    if (gnt !== 3'b000 || timeout !== 1'b1) begin
      fails++;
      $display("FAIL to_revoke got gnt=%b timeout=%b want 000 1", gnt, timeout);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      pulses += timeout;
      tests++;
      if (gnt !== 3'b000) begin
        fails++;
        $display("FAIL to_locked%0d got gnt=%b want 000", c, gnt);
      end
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL to_single_pulse got extra pulses=%0d want 0", pulses);
    end
    req = 0;
    tick();
    req = 3'b001;
    tick();
    tests++;
    if (gnt !== 3'b001 || sel !== 2'b01) begin
      fails++;
      $display("FAIL to_regrant got gnt=%b sel=%b want 001 01", gnt, sel);
    end
`else
    for (int c = 0; c < 100; c++) begin
      pulses += timeout;
      if (gnt !== 3'b001) begin
        tests++;
        fails++;
        $display("FAIL noto_hold%0d got gnt=%b want 001", c, gnt);
      end
      tick();
    end
    tests++;
    if (gnt !== 3'b001 || pulses !== 0) begin
      fails++;
      $display("FAIL noto_final got gnt=%b timeout_pulses=%0d want 001 0", gnt, pulses);
    end
`endif
    req = 0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_contention();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
